// File: rtl/counter_ctrl_pkg.sv
// Shared encodings for the counter run-state sequencer: FSM states, control-bus
// bit positions and the command words driven onto the counter's control bus.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_IDLE  = 2'b01,
        ST_RUN   = 2'b10,
        ST_PAUSE = 2'b11
    } state_e;

    localparam int CTR_CLR   = 0;
    localparam int CTR_STOP  = 1;
    localparam int CTR_START = 2;

    // A clear also stops the counter so it never free-runs from zero.
    localparam logic [2:0] CMD_CLR   = 3'b011;
    localparam logic [2:0] CMD_STOP  = 3'b010;
    localparam logic [2:0] CMD_START = 3'b100;

endpackage

// File: rtl/counter_ctrl_key_debounce.sv
// One push-button channel: 2-FF synchroniser, stability counter and a
// single-cycle press event on each accepted 0->1 change of the stable level.
module key_debounce #(
    parameter int DEB_CYC = 200000,
    parameter int DEB_W   = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= key;
            sync2    <= sync1;
            stable_d <= stable;
            // Any sample agreeing with the stable level restarts the count.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == DEB_W'(DEB_CYC - 1)) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_d;

endmodule

// File: rtl/counter_ctrl.sv
// Key front end and run-state sequencer for the 0..99 display counter.
// Optional auto-stop at STOP_NUM is enabled by defining COUNTER_CTRL_AUTOSTOP_EN.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int         DEB_CYC  = 200000,
    parameter int         DEB_W    = 18,
    parameter logic [7:0] STOP_NUM = 8'd99
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_key_clr,
    input  logic       i_key_stop,
    input  logic       i_key_start,
    input  logic [7:0] i_num,
    output logic [2:0] o_ctr,
    output logic [1:0] o_state,
    output logic       o_run,
    output logic       o_done
);

    logic [2:0] press;
    logic [2:0] raw_keys;
    state_e     state;
    state_e     state_nxt;
    logic [2:0] ctr;
    logic [2:0] ctr_nxt;
    logic       run;
    logic       auto_stop;

    assign raw_keys[CTR_CLR]   = i_key_clr;
    assign raw_keys[CTR_STOP]  = i_key_stop;
    assign raw_keys[CTR_START] = i_key_start;

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(
            .DEB_CYC (DEB_CYC),
            .DEB_W   (DEB_W)
        ) u_deb (
            .clk   (i_clk),
            .rst_n (i_rst_n),
            .key   (raw_keys[k]),
            .press (press[k])
        );
    end

`ifdef COUNTER_CTRL_AUTOSTOP_EN
    logic [7:0] num_prev;
    logic       done;
    logic       done_nxt;

    assign auto_stop = (state == ST_RUN) && (num_prev != STOP_NUM) && (i_num == STOP_NUM);
`else
    logic unused_num;

    assign unused_num = ^{i_num, STOP_NUM};
    assign auto_stop  = 1'b0;
`endif

    // Priority clear > stop > start > auto-stop; a losing or ignored event is dropped.
    always_comb begin
        state_nxt = state;
        ctr_nxt   = 3'b000;
        if (state == ST_INIT) begin
            ctr_nxt   = CMD_CLR;
            state_nxt = ST_IDLE;
        end else if (press[CTR_CLR]) begin
            ctr_nxt   = CMD_CLR;
            state_nxt = ST_IDLE;
        end else if (press[CTR_STOP]) begin
            if (state == ST_RUN) begin
                ctr_nxt   = CMD_STOP;
                state_nxt = ST_PAUSE;
            end
        end else if (press[CTR_START]) begin
            if (state != ST_RUN) begin
                ctr_nxt   = CMD_START;
                state_nxt = ST_RUN;
            end
        end else if (auto_stop) begin
            ctr_nxt   = CMD_STOP;
            state_nxt = ST_PAUSE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_INIT;
            ctr   <= 3'b000;
            run   <= 1'b0;
        end else begin
            state <= state_nxt;
            ctr   <= ctr_nxt;
            run   <= (state_nxt == ST_RUN);
        end
    end

`ifdef COUNTER_CTRL_AUTOSTOP_EN
    always_comb begin
        done_nxt = done;
        if (ctr_nxt == CMD_CLR || ctr_nxt == CMD_START) begin
            done_nxt = 1'b0;
        end else if (auto_stop && ctr_nxt == CMD_STOP && !(|press)) begin
            done_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            num_prev <= 8'd0;
            done     <= 1'b0;
        end else begin
            num_prev <= i_num;
            done     <= done_nxt;
        end
    end

    assign o_done = done;
`else
    assign o_done = 1'b0;
`endif

    assign o_ctr   = ctr;
    assign o_state = state;
    assign o_run   = run;

endmodule

// File: tb/tb_counter_ctrl.sv
// Bench for counter_ctrl: directed scenarios plus randomized key activity,
// all compared each cycle against a run-length debounce and command model.
module tb_counter_ctrl;

    localparam int         DEB_CYC  = 4;
    localparam int         DEB_W    = 3;
    localparam logic [7:0] STOP_NUM = 8'd5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_clr = 1'b0;
    logic       key_stop = 1'b0;
    logic       key_start = 1'b0;
    logic [7:0] num = 8'd0;
    logic [2:0] ctr;
    logic [1:0] state;
    logic       run;
    logic       done;

    int n_tests = 0;
    int n_fail = 0;

    // Reference model state
    logic [2:0] m_stable;
    int         m_cnt [3];
    logic [2:0] d1, d2, d3;
    int         m_state;
    logic [2:0] m_ctr;
    logic       m_done;
    logic [7:0] m_prev;

    always #5 clk = ~clk;

    counter_ctrl #(
        .DEB_CYC  (DEB_CYC),
        .DEB_W    (DEB_W),
        .STOP_NUM (STOP_NUM)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_key_clr   (key_clr),
        .i_key_stop  (key_stop),
        .i_key_start (key_start),
        .i_num       (num),
        .o_ctr       (ctr),
        .o_state     (state),
        .o_run       (run),
        .o_done      (done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_stable = 3'b000;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        d1 = 3'b000;
        d2 = 3'b000;
        d3 = 3'b000;
        m_state = 0;
        m_ctr = 3'b000;
        m_done = 1'b0;
        m_prev = 8'd0;
    endtask

    // A level is accepted after DEB_CYC consecutive differing samples; the
    // resulting press reaches the control bus three edges later.
    task automatic model_edge(input logic [2:0] raw, input logic [7:0] n);
        logic [2:0] p;
        logic [2:0] ev;
        p = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (raw[i] != m_stable[i]) begin
                m_cnt[i]++;
                if (m_cnt[i] == DEB_CYC) begin
                    m_stable[i] = raw[i];
                    m_cnt[i] = 0;
                    p[i] = raw[i];
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        ev = d3;
        d3 = d2;
        d2 = d1;
        d1 = p;
        m_ctr = 3'b000;
        if (m_state == 0) begin
            m_ctr = 3'b011;
            m_state = 1;
        end else if (ev[0]) begin
            m_ctr = 3'b011;
            m_state = 1;
        end else if (ev[1]) begin
            if (m_state == 2) begin
                m_ctr = 3'b010;
                m_state = 3;
            end
        end else if (ev[2]) begin
            if (m_state != 2) begin
                m_ctr = 3'b100;
                m_state = 2;
            end
        end
`ifdef COUNTER_CTRL_AUTOSTOP_EN
        else if (m_state == 2 && m_prev != STOP_NUM && n == STOP_NUM) begin
            m_ctr = 3'b010;
            m_state = 3;
            m_done = 1'b1;
        end
        if (m_ctr == 3'b011 || m_ctr == 3'b100) m_done = 1'b0;
`endif
        m_prev = n;
    endtask

    task automatic check_all(input string phase);
        check({phase, "_ctr"}, {5'd0, ctr}, {5'd0, m_ctr});
        check({phase, "_state"}, {6'd0, state}, 8'(m_state));
        check({phase, "_run"}, {7'd0, run}, {7'd0, (m_state == 2)});
        check({phase, "_done"}, {7'd0, done}, {7'd0, m_done});
    endtask

    task automatic step(input string phase);
        @(posedge clk);
        if (rst_n) model_edge({key_start, key_stop, key_clr}, num);
        else model_reset();
        #1;
        check_all(phase);
    endtask

    initial begin
        int         hold [3];
        logic [2:0] lv;

        model_reset();
        #1;
        check_all("reset");
        step("reset");
        step("reset");

        // Power-up sequence
        rst_n = 1'b1;
        step("init");
        check("init_pulse", {5'd0, ctr}, 8'h03);
        step("init");
        check("idle_after_init", {6'd0, state}, 8'h01);

        // Start held 10 cycles from IDLE; the pulse lands on edge 7
        key_start = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step("start");
            if (i == 7) check("start_edge7", {5'd0, ctr}, 8'h04);
        end
        key_start = 1'b0;
        for (int i = 0; i < 10; i++) step("start_release");

        // Bounce on stop: 3 cycles rejected, 5 cycles accepted
        key_stop = 1'b1;
        for (int i = 0; i < 3; i++) step("bounce");
        key_stop = 1'b0;
        for (int i = 0; i < 8; i++) step("bounce");
        check("bounce_still_run", {6'd0, state}, 8'h02);
        key_stop = 1'b1;
        for (int i = 0; i < 5; i++) step("stop");
        key_stop = 1'b0;
        for (int i = 0; i < 6; i++) step("stop");
        check("paused", {6'd0, state}, 8'h03);

        // Clear and start together in PAUSE: clear wins
        key_clr = 1'b1;
        key_start = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step("clr_start");
            if (i == 7) check("clr_wins", {5'd0, ctr}, 8'h03);
        end
        key_clr = 1'b0;
        key_start = 1'b0;
        for (int i = 0; i < 6; i++) step("clr_start");
        check("idle_after_clr", {6'd0, state}, 8'h01);

        // Stop in IDLE is ignored
        key_stop = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step("idle_stop");
            if (i == 7) check("idle_stop_nopulse", {5'd0, ctr}, 8'h00);
        end
        key_stop = 1'b0;
        for (int i = 0; i < 6; i++) step("idle_stop");

        // Randomized key activity with random counter values
        for (int k = 0; k < 3; k++) hold[k] = 0;
        lv = 3'b000;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (hold[k] == 0) begin
                    lv[k] = (k == 0) ? ($urandom_range(0, 5) == 0) : 1'($urandom_range(0, 1));
                    hold[k] = $urandom_range(1, 8);
                end else begin
                    hold[k]--;
                end
            end
            {key_start, key_stop, key_clr} = lv;
            num = 8'($urandom_range(0, 7));
            step("rand");
        end
        {key_start, key_stop, key_clr} = 3'b000;
        num = 8'd0;
        for (int i = 0; i < 8; i++) step("settle");

        // Reach RUN, then assert reset asynchronously mid-cycle
        key_clr = 1'b1;
        for (int i = 0; i < 6; i++) step("pre_rst");
        key_clr = 1'b0;
        for (int i = 0; i < 6; i++) step("pre_rst");
        key_start = 1'b1;
        for (int i = 0; i < 6; i++) step("pre_rst");
        key_start = 1'b0;
        for (int i = 0; i < 6; i++) step("pre_rst");
        check("run_before_rst", {6'd0, state}, 8'h02);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        step("in_rst");
        step("in_rst");
        rst_n = 1'b1;
        step("replay");
        check("replay_pulse", {5'd0, ctr}, 8'h03);

        // Start held through reset is accepted DEB_CYC+3 edges after release
        key_start = 1'b1;
        #2;
        rst_n = 1'b0;
        model_reset();
        step("held_rst");
        rst_n = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step("held");
            if (i == DEB_CYC + 3) check("held_start", {5'd0, ctr}, 8'h04);
        end
        key_start = 1'b0;
        for (int i = 0; i < 6; i++) step("held");

`ifdef COUNTER_CTRL_AUTOSTOP_EN
        // Auto-stop on the 4->5 transition while running
        num = 8'd4;
        step("auto");
        num = 8'd5;
        step("auto");
        check("auto_ctr", {5'd0, ctr}, 8'h02);
        check("auto_done", {7'd0, done}, 8'h01);
        for (int i = 0; i < 3; i++) step("auto");
        key_start = 1'b1;
        for (int i = 0; i < 6; i++) step("auto_restart");
        key_start = 1'b0;
        for (int i = 0; i < 4; i++) step("auto_restart");
        check("auto_done_cleared", {7'd0, done}, 8'h00);
        check("auto_rerun", {6'd0, state}, 8'h02);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Push-button front end and run-state sequencer for the 0..99 display counter.
- Synchronises and debounces three raw keys (clear, stop, start), then tracks the run state in an FSM.
- Drives the counter's 3-bit control bus with one-cycle command pulses: bit0 clear, bit1 stop, bit2 start.
- Sits between the board keys and the counter; also receives the counter value back for status and auto-stop.

Parameters:
- DEB_CYC, 200000: consecutive stable cycles required before a key level is accepted; minimum 2.
- DEB_W, 18: width of each debounce counter; must satisfy 2^DEB_W > DEB_CYC.
- STOP_NUM, 99: auto-stop target value; used only with the optional feature.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_key_clr  input  1  raw clear key, asynchronous, high = pressed.
- i_key_stop  input  1  raw stop key, asynchronous, high = pressed.
- i_key_start  input  1  raw start key, asynchronous, high = pressed.
- i_num  input  8  current counter value, synchronous to i_clk.
- o_ctr  output  3  command pulses to the counter: [0] clear, [1] stop, [2] start.
- o_state  output  2  current FSM state.
- o_run  output  1  high while in ST_RUN.
- o_done  output  1  sticky auto-stop flag.

Behaviour:
- Clock and reset: one clock, i_clk. i_rst_n is asynchronous, active-low; the polarity and synchronicity are fixed.
- Reset values (while i_rst_n = 0): all registers clear, o_ctr=3'b000, o_state=ST_INIT, o_run=0, o_done=0, sync/debounce stable levels=0, debounce counters=0.
- Synchroniser: each key passes through a 2-FF synchroniser.
- Debounce, per key:
  - Counter clears whenever the synced level equals the stable level.
  - Otherwise it increments; when it reaches DEB_CYC-1, the stable level takes the synced level and the counter clears.
  - Pulses shorter than DEB_CYC cycles are never accepted.
- Press event: 0->1 transition of a stable level, one cycle wide. Release events are ignored.
- Latency: an o_ctr pulse appears exactly DEB_CYC+3 rising edges after the first edge that samples the new raw level.
- Simultaneous events: when several press events occur in the same cycle, priority is clear > stop > start. Only the winner acts; the rest are discarded.
- o_ctr is registered and high for exactly one cycle per command; it is 3'b000 otherwise.
- FSM state ST_INIT (2'b00): entered on reset. On the first clock after reset release, emits o_ctr=3'b011 (clear+stop) and moves to ST_IDLE.
- FSM state ST_IDLE (2'b01):
  - start -> o_ctr=3'b100, go to ST_RUN.
  - stop -> ignored, no pulse.
  - clear -> o_ctr=3'b011, stay in ST_IDLE.
- FSM state ST_RUN (2'b10):
  - stop -> o_ctr=3'b010, go to ST_PAUSE.
  - start -> ignored.
  - clear -> o_ctr=3'b011, go to ST_IDLE.
- FSM state ST_PAUSE (2'b11):
  - start -> o_ctr=3'b100, go to ST_RUN.
  - stop -> ignored.
  - clear -> o_ctr=3'b011, go to ST_IDLE.
- o_run = (o_state==ST_RUN), registered alongside the state.
- Reset mid-operation: the FSM returns to ST_INIT, any pending debounce progress is lost, and the ST_INIT sequence is replayed after release.
- Held keys: a key held through reset release is accepted as a press DEB_CYC+3 cycles later, then acted on per the current state.

Optional Feature:
- Macro: COUNTER_CTRL_AUTOSTOP_EN.
- Defined:
  - In ST_RUN, when i_num changes to STOP_NUM (registered previous value != STOP_NUM and i_num==STOP_NUM), emit o_ctr=3'b010, go to ST_PAUSE, and set o_done=1.
  - A key event in the same cycle takes priority over auto-stop.
  - o_done clears on any clear or start command.
- Not defined: o_done is tied to 0, no i_num comparison logic exists, and i_num is unused.

Decomposition:
- Package counter_ctrl_pkg:
  - State encodings ST_INIT/ST_IDLE/ST_RUN/ST_PAUSE.
  - Bit indices CTR_CLR=0, CTR_STOP=1, CTR_START=2.
  - Command constants CMD_CLR=3'b011, CMD_STOP=3'b010, CMD_START=3'b100.
- Sub-module key_debounce: synchroniser, debounce counter and rising-edge event output. Instantiated three times, parameterised by DEB_CYC/DEB_W.

Test Plan:
- Power-up (DEB_CYC=4): release i_rst_n -> o_ctr=3'b011 for exactly 1 cycle, then o_state=01, o_run=0.
- Start press held 10 cycles in ST_IDLE -> o_ctr=3'b100 at edge 7 after the raw rise, o_state=10, o_run=1; the release produces no pulse.
- Bounce: i_key_stop high for 3 cycles, then low, in ST_RUN -> no pulse and o_state stays 10. Holding 5 cycles -> o_ctr=3'b010, o_state=11.
- Clear and start raised on the same edge in ST_PAUSE -> only o_ctr=3'b011, o_state=01. Stop in ST_IDLE -> o_ctr stays 000.
- Assert i_rst_n=0 mid-ST_RUN for 2 cycles -> outputs at reset values immediately (asynchronously); after release, o_ctr=3'b011 replays.
- AUTOSTOP_EN with STOP_NUM=5: in ST_RUN, drive i_num 4->5 -> o_ctr=3'b010 one cycle later, o_state=11, o_done=1. A following start clears o_done and returns to ST_RUN.
